uart_tx_ctrl: RTL and testbench

- Buffered transmit controller between the CPU data-bus store path and the simulation UART device.
- CPU bytes written to the TX data address are queued in a FIFO. A small FSM drains them to the device bus one write at a time, with a programmable pacing gap between writes.
- A status register reports FIFO level, full/empty, a sticky overflow flag and busy, so software can poll before writing.

---
 rtl/uart_tx_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Buffered UART transmit controller: CPU stores fill a byte FIFO that a paced FSM drains to the
// device bus. Define UART_TX_IRQ_EN to add the tx_irq output and status bit [12].
module uart_tx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TX_GAP     = 4,
    parameter logic [15:0] TXD_ADDR   = 16'h0000,
    parameter logic [15:0] STAT_ADDR  = 16'h0004,
    parameter logic [31:0] DEV_BASE   = 32'ha000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        ren,
    output logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic [31:0] dev_addr,
    output logic        dev_wen,
    output logic [31:0] dev_wdata,
    output logic [3:0]  dev_wstrb,
`ifdef UART_TX_IRQ_EN
    output logic        tx_irq,
`endif
    output logic        tx_busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(TX_GAP - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic               ovf_q, ovf_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        status;

    logic push_req, stat_rd, pop, full, empty, push_ok, ovf_set;

    // Upper address, data and strobe bits are intentionally not decoded.
    logic unused_bits;
    assign unused_bits = ^{addr[31:16], wdata[31:8], wstrb[3:1]};

    assign push_req = wen & wstrb[0] & (addr[15:0] == TXD_ADDR);
    assign stat_rd  = ren & (addr[15:0] == STAT_ADDR);
    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign pop      = (state_q == StIssue);
    // A pop at the same edge frees the slot a full-FIFO push needs.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (level_d != '0) state_d = StIssue;
            end
            StIssue: begin
                state_d   = StGap;
                gap_cnt_d = GAP_LOAD;
            end
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = (level_d != '0) ? StIssue : StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef UART_TX_IRQ_EN
    logic pending_q, pending_d, tx_irq_q;
    assign pending_d = (pop & (level_d == '0)) | (pending_q & ~stat_rd);
    assign tx_irq    = tx_irq_q;
`endif

    always_comb begin
        status     = '0;
        status[7:0] = 8'(level_q);
        status[8]  = empty;
        status[9]  = full;
        status[10] = ovf_q;
        status[11] = tx_busy;
`ifdef UART_TX_IRQ_EN
        status[12] = pending_q;
`endif
    end

    assign ovf_d   = ovf_set | (ovf_q & ~stat_rd);
    assign rdata_d = ren ? (stat_rd ? status : 32'h0) : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            tx_irq_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            tx_irq_q  <= pending_d & (level_d == '0);
        end
    end
`endif

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    assign dev_addr  = DEV_BASE;
    assign dev_wen   = (state_q == StIssue);
    assign dev_wstrb = dev_wen ? 4'b0001 : 4'b0000;
    assign dev_wdata = dev_wen ? {24'h0, mem_q[rd_ptr_q]} : 32'h0;
    assign tx_busy   = ~empty | (state_q != StIdle);
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a queue-based model predicts device writes, status reads,
// busy and (with UART_TX_IRQ_EN) tx_irq; a negedge monitor compares against the DUT.
module tb_uart_tx_ctrl;
    localparam int          DEPTH    = 8;
    localparam int          TX_GAP   = 4;
    localparam logic [15:0] TXD      = 16'h0000;
    localparam logic [15:0] STAT     = 16'h0004;
    localparam logic [31:0] DEV_BASE = 32'ha000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic [31:0] wdata = '0;
    logic        wen = 1'b0;
    logic [3:0]  wstrb = '0;
    logic [31:0] dev_addr;
    logic        dev_wen;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_wstrb;
    logic        tx_busy;
`ifdef UART_TX_IRQ_EN
    logic        tx_irq;
`endif

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .TX_GAP    (TX_GAP),
        .TXD_ADDR  (TXD),
        .STAT_ADDR (STAT),
        .DEV_BASE  (DEV_BASE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .ren      (ren),
        .rdata    (rdata),
        .wdata    (wdata),
        .wen      (wen),
        .wstrb    (wstrb),
        .dev_addr (dev_addr),
        .dev_wen  (dev_wen),
        .dev_wdata(dev_wdata),
        .dev_wstrb(dev_wstrb),
`ifdef UART_TX_IRQ_EN
        .tx_irq   (tx_irq),
`endif
        .tx_busy  (tx_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents as a queue, issue slots from "at most one write per
    // TX_GAP+1 cycles, as soon as a byte is present".
    typedef struct {
        int          cyc;
        logic [31:0] val;
    } item_t;

    item_t       dev_q[$];
    item_t       rd_q[$];
    logic [7:0]  fifo_m[$];
    int          last_issue = -1000;
    bit          issue_cur = 0, ovf_m = 0, pend_m = 0, busy_m = 0, irq_m = 0;
    int          k, lvl;
    bit          push_req, stat, pop, set_ovf;
    logic [31:0] st;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_m.delete();
            dev_q.delete();
            rd_q.delete();
            issue_cur  = 0;
            ovf_m      = 0;
            pend_m     = 0;
            busy_m     = 0;
            irq_m      = 0;
            last_issue = -1000;
        end else begin
            cyc++;
            k        = cyc;
            push_req = wen && wstrb[0] && (addr[15:0] == TXD);
            stat     = ren && (addr[15:0] == STAT);
            lvl      = fifo_m.size();
            st       = '0;
            st[7:0]  = lvl[7:0];
            st[8]    = (lvl == 0);
            st[9]    = (lvl == DEPTH);
            st[10]   = ovf_m;
            st[11]   = busy_m;
`ifdef UART_TX_IRQ_EN
            st[12]   = pend_m;
`endif
            if (ren) rd_q.push_back('{k, stat ? st : 32'h0});
            pop = issue_cur;
            if (pop) void'(fifo_m.pop_front());
            set_ovf = 0;
            if (push_req) begin
                if (fifo_m.size() < DEPTH) fifo_m.push_back(wdata[7:0]);
                else set_ovf = 1;
            end
            if (set_ovf) ovf_m = 1;
            else if (stat) ovf_m = 0;
            if (pop && fifo_m.size() == 0) pend_m = 1;
            else if (stat) pend_m = 0;
            irq_m     = pend_m && (fifo_m.size() == 0);
            issue_cur = (fifo_m.size() > 0) && (k >= last_issue + TX_GAP + 1);
            if (issue_cur) begin
                last_issue = k;
                dev_q.push_back('{k, {24'h0, fifo_m[0]}});
            end
            busy_m = (fifo_m.size() > 0) || ((k - last_issue) <= TX_GAP);
        end
    end

    item_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dev_wen) begin
                if (dev_q.size() == 0) begin
                    check("dev_unexpected_wen", {31'b0, dev_wen}, 32'h0);
                end else begin
                    e = dev_q.pop_front();
                    check("dev_cycle", cyc, e.cyc);
                    check("dev_wdata", dev_wdata, e.val);
                    check("dev_wstrb", {28'b0, dev_wstrb}, 32'h1);
                    check("dev_addr", dev_addr, DEV_BASE);
                end
            end else if (dev_q.size() > 0 && dev_q[0].cyc <= cyc) begin
                check("dev_missing_wen", {31'b0, dev_wen}, 32'h1);
                void'(dev_q.pop_front());
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                e = rd_q.pop_front();
                check("rdata", rdata, e.val);
            end
            check("tx_busy", {31'b0, tx_busy}, {31'b0, busy_m});
`ifdef UART_TX_IRQ_EN
            check("tx_irq", {31'b0, tx_irq}, {31'b0, irq_m});
`endif
        end
    end

    task automatic drive(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d,
                         input logic [3:0] s);
        @(negedge clk);
        wen   = w;
        ren   = r;
        addr  = {16'($urandom), a};
        wdata = {24'($urandom), d};
        wstrb = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 8'h0, 4'h0);
    endtask

    task automatic push(input logic [7:0] b);
        drive(1'b1, 1'b0, TXD, b, 4'b0001);
    endtask

    task automatic rd(input logic [15:0] a);
        drive(1'b0, 1'b1, a, 8'h0, 4'h0);
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_dev_wen"}, {31'b0, dev_wen}, 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_tx_busy"}, {31'b0, tx_busy}, 32'h0);
        check({tag, "_dev_wstrb"}, {28'b0, dev_wstrb}, 32'h0);
        check({tag, "_dev_wdata"}, dev_wdata, 32'h0);
        check({tag, "_dev_addr"}, dev_addr, DEV_BASE);
    endtask

    initial begin
        #12;
        reset_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        rd(STAT);
        idle(2);

        // Two back-to-back bytes: first write right after its push edge, second TX_GAP+1 later.
        push(8'h48);
        push(8'h69);
        idle(15);

        // Ignored writes: wrong address, and TXD without strobe bit 0.
        drive(1'b1, 1'b0, 16'h0008, 8'h55, 4'b0001);
        drive(1'b1, 1'b0, TXD, 8'h66, 4'b1110);
        rd(STAT);
        idle(10);

        // Overflow burst, then two reads to see the sticky flag clear.
        for (int i = 0; i < 12; i++) push(8'h30 + 8'(i));
        rd(STAT);
        rd(STAT);
        idle(70);

        // Status mid-transfer.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        idle(2);
        rd(STAT);
        rd(16'h0010);
        idle(30);

        // Single byte then a status read (pending / irq path).
        push(8'ha5);
        idle(3);
        rd(STAT);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            logic [3:0]  s;
            int          sel;
            sel = $urandom_range(0, 3);
            a   = (sel == 0) ? TXD : (sel == 1) ? STAT : (sel == 2) ? 16'h0008 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = TXD;
            s   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0001;
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, a, 8'($urandom), s);
        end
        idle(80);

        // Asynchronous reset mid-GAP with bytes still queued.
        for (int i = 0; i < 4; i++) push(8'hc0 + 8'(i));
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(STAT);
        idle(20);

        check("dev_queue_drained", dev_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
